// File: rtl/gray_bcd_scan_display.sv
// Samples a Gray word, converts it to binary, then to BCD with a shift-add-3 engine,
// and time-multiplexes the digits onto an active-low seven-segment display.
module gray_bcd_scan_display #(
    parameter int N           = 8,
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int BLANK_LZ    = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N-1:0]      gray,
    input  logic              load,
    output logic              busy,
    output logic [N-1:0]      bin,
    output logic [N-1:0]      leds,
    output logic [6:0]        seg,
    output logic [DIGITS-1:0] an,
    output logic              ovf
);
    // state | meaning
    // IDLE  | waiting for load; display holds last result
    // CONV  | one shift-add-3 step per cycle, N steps
    // DONE  | copy BCD result and overflow into display registers
    typedef enum logic [1:0] {S_IDLE, S_CONV, S_DONE} state_t;

    localparam int BW = DIGITS * 4 + 4;
    localparam int DW = DIGITS * 4;
    localparam int CW = $clog2(N + 1);
    localparam int RW = $clog2(REFRESH_DIV);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    state_t        r_state;
    logic          r_busy;
    logic [N-1:0]  r_bin;
    logic [N-1:0]  r_bits;
    logic [BW-1:0] r_bcd;
    logic          r_lost;
    logic [CW-1:0] r_cnt;
    logic [DW-1:0] r_disp;
    logic          r_ovf;
    logic [RW-1:0] r_div;
    logic [IW-1:0] r_idx;

    logic [N-1:0]  w_bin;
    logic [BW-1:0] w_adj;
    logic [3:0]    w_nib;
    logic          w_blank;
    logic [6:0]    w_seg;

    function automatic logic [6:0] f_dec(input logic [3:0] nib);
        case (nib)
            4'd0:    f_dec = 7'b0000001;
            4'd1:    f_dec = 7'b1001111;
            4'd2:    f_dec = 7'b0010010;
            4'd3:    f_dec = 7'b0000110;
            4'd4:    f_dec = 7'b1001100;
            4'd5:    f_dec = 7'b0100100;
            4'd6:    f_dec = 7'b0100000;
            4'd7:    f_dec = 7'b0001111;
            4'd8:    f_dec = 7'b0000000;
            4'd9:    f_dec = 7'b0000100;
            default: f_dec = 7'h7F;
        endcase
    endfunction

    // Each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        w_bin = '0;
        for (int i = 0; i < N; i++) begin
            w_bin[i] = ^(gray >> i);
        end
    end

    always_comb begin
        w_adj = r_bcd;
        for (int d = 0; d <= DIGITS; d++) begin
            if (r_bcd[d*4 +: 4] > 4'd4) begin
                w_adj[d*4 +: 4] = r_bcd[d*4 +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_bin   <= '0;
            r_bits  <= '0;
            r_bcd   <= '0;
            r_lost  <= 1'b0;
            r_cnt   <= '0;
            r_disp  <= '0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (load) begin
                        r_bin   <= w_bin;
                        r_bits  <= w_bin;
                        r_bcd   <= '0;
                        r_lost  <= 1'b0;
                        r_cnt   <= CW'(N);
                        r_busy  <= 1'b1;
                        r_state <= S_CONV;
                    end
                end
                S_CONV: begin
                    if (r_cnt != '0) begin
                        r_bcd  <= {w_adj[BW-2:0], r_bits[N-1]};
                        r_bits <= {r_bits[N-2:0], 1'b0};
                        // A bit shifted out of the top would otherwise wrap silently.
                        r_lost <= r_lost | w_adj[BW-1];
                        r_cnt  <= r_cnt - CW'(1);
                    end else begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_disp  <= r_bcd[DW-1:0];
                    r_ovf   <= r_lost | (|r_bcd[BW-1:DW]);
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div <= '0;
            r_idx <= '0;
        end else if (r_div == RW'(REFRESH_DIV - 1)) begin
            r_div <= '0;
            r_idx <= (r_idx == IW'(DIGITS - 1)) ? '0 : r_idx + IW'(1);
        end else begin
            r_div <= r_div + RW'(1);
        end
    end

    // Walk from the top digit down so blanking knows whether anything above is nonzero.
    always_comb begin
        logic v_nz;
        v_nz    = 1'b0;
        w_nib   = '0;
        w_blank = 1'b0;
        for (int d = DIGITS - 1; d >= 0; d--) begin
            v_nz = v_nz | (r_disp[d*4 +: 4] != 4'd0);
            if (int'(r_idx) == d) begin
                w_nib   = r_disp[d*4 +: 4];
                w_blank = (BLANK_LZ != 0) && (d != 0) && !v_nz;
            end
        end
        if (!rst_n)       w_seg = 7'h7F;
        else if (r_ovf)   w_seg = 7'b1111110;
        else if (w_blank) w_seg = 7'h7F;
        else              w_seg = f_dec(w_nib);
    end

    assign seg  = w_seg;
    assign an   = rst_n ? ~(DIGITS'(1) << r_idx) : '1;
    assign busy = r_busy;
    assign bin  = r_bin;
    assign leds = r_bin;
    assign ovf  = r_ovf;
endmodule

// File: tb/tb_gray_bcd_scan_display.sv
// Directed bench: three display configurations driven from shared stimulus,
// vector table for conversions plus hand sequences for latency, busy-load and reset abort.
module tb_gray_bcd_scan_display;
    localparam logic [6:0] S0 = 7'b0000001, S1 = 7'b1001111, S2 = 7'b0010010,
                           S3 = 7'b0000110, S4 = 7'b1001100, S5 = 7'b0100100,
                           S6 = 7'b0100000, S7 = 7'b0001111, S8 = 7'b0000000,
                           S9 = 7'b0000100, SB = 7'h7F,      SD = 7'b1111110;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] gray = 8'h00;
    logic       load = 1'b0;

    logic       busy_m, busy_n, busy_d, ovf_m, ovf_n, ovf_d;
    logic [7:0] bin_m, bin_n, bin_d, leds_m, leds_n, leds_d;
    logic [6:0] seg_m, seg_n, seg_d;
    logic [2:0] an_m, an_n;
    logic [1:0] an_d;

    int n_cmp = 0;
    int n_bad = 0;

    logic [6:0] cap_m [3];
    logic [6:0] cap_n [3];
    logic [6:0] cap_d [2];

    typedef struct {
        logic [7:0]  g;
        logic [7:0]  b;
        logic [20:0] sm;   // {digit2, digit1, digit0}, blanking on
        logic [20:0] sn;   // blanking off
        logic [13:0] sd;   // two-digit instance
        logic        od;   // two-digit overflow
    } vec_t;

    vec_t vecs [9];

    gray_bcd_scan_display #(.N(8), .DIGITS(3), .REFRESH_DIV(4), .BLANK_LZ(1)) u_main (
        .clk(clk), .rst_n(rst_n), .gray(gray), .load(load), .busy(busy_m), .bin(bin_m),
        .leds(leds_m), .seg(seg_m), .an(an_m), .ovf(ovf_m));
    gray_bcd_scan_display #(.N(8), .DIGITS(3), .REFRESH_DIV(4), .BLANK_LZ(0)) u_nolz (
        .clk(clk), .rst_n(rst_n), .gray(gray), .load(load), .busy(busy_n), .bin(bin_n),
        .leds(leds_n), .seg(seg_n), .an(an_n), .ovf(ovf_n));
    gray_bcd_scan_display #(.N(8), .DIGITS(2), .REFRESH_DIV(4), .BLANK_LZ(1)) u_d2 (
        .clk(clk), .rst_n(rst_n), .gray(gray), .load(load), .busy(busy_d), .bin(bin_d),
        .leds(leds_d), .seg(seg_d), .an(an_d), .ovf(ovf_d));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_load(input logic [7:0] g);
        @(negedge clk);
        gray = g;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        for (k = 0; k < 40; k++) begin
            if (!busy_m) break;
            @(negedge clk);
        end
        chk("idle_timeout", {31'd0, busy_m}, 32'd0);
    endtask

    task automatic capture();
        for (int d = 0; d < 3; d++) begin cap_m[d] = 7'h55; cap_n[d] = 7'h55; end
        for (int d = 0; d < 2; d++) cap_d[d] = 7'h55;
        repeat (12) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                if (an_m[d] == 1'b0) cap_m[d] = seg_m;
                if (an_n[d] == 1'b0) cap_n[d] = seg_n;
            end
            for (int d = 0; d < 2; d++) if (an_d[d] == 1'b0) cap_d[d] = seg_d;
        end
    endtask

    task automatic chk_disp(input string tag, input logic [20:0] sm, input logic [20:0] sn,
                            input logic [13:0] sd);
        capture();
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("%s_main_d%0d", tag, d), {25'd0, cap_m[d]}, {25'd0, sm[d*7 +: 7]});
            chk($sformatf("%s_nolz_d%0d", tag, d), {25'd0, cap_n[d]}, {25'd0, sn[d*7 +: 7]});
        end
        for (int d = 0; d < 2; d++)
            chk($sformatf("%s_d2_d%0d", tag, d), {25'd0, cap_d[d]}, {25'd0, sd[d*7 +: 7]});
    endtask

    task automatic apply(input int i);
        do_load(vecs[i].g);
        chk($sformatf("v%0d_bin", i), {24'd0, bin_m}, {24'd0, vecs[i].b});
        chk($sformatf("v%0d_leds", i), {24'd0, leds_m}, {24'd0, vecs[i].b});
        chk($sformatf("v%0d_bin_d2", i), {24'd0, bin_d}, {24'd0, vecs[i].b});
        chk($sformatf("v%0d_busy", i), {31'd0, busy_m}, 32'd1);
        wait_idle();
        chk($sformatf("v%0d_ovf_main", i), {31'd0, ovf_m}, 32'd0);
        chk($sformatf("v%0d_ovf_nolz", i), {31'd0, ovf_n}, 32'd0);
        chk($sformatf("v%0d_ovf_d2", i), {31'd0, ovf_d}, {31'd0, vecs[i].od});
        chk_disp($sformatf("v%0d", i), vecs[i].sm, vecs[i].sn, vecs[i].sd);
    endtask

    initial begin
        logic [2:0] an_tab [3];
        an_tab[0] = 3'b110; an_tab[1] = 3'b101; an_tab[2] = 3'b011;

        vecs[0] = '{8'h80, 8'hFF, {S2, S5, S5}, {S2, S5, S5}, {SD, SD}, 1'b1};
        vecs[1] = '{8'h0F, 8'h0A, {SB, S1, S0}, {S0, S1, S0}, {S1, S0}, 1'b0};
        vecs[2] = '{8'h56, 8'h64, {S1, S0, S0}, {S1, S0, S0}, {SD, SD}, 1'b1};
        vecs[3] = '{8'h52, 8'h63, {SB, S9, S9}, {S0, S9, S9}, {S9, S9}, 1'b0};
        vecs[4] = '{8'h00, 8'h00, {SB, SB, S0}, {S0, S0, S0}, {SB, S0}, 1'b0};
        vecs[5] = '{8'h7F, 8'h55, {SB, S8, S5}, {S0, S8, S5}, {S8, S5}, 1'b0};
        vecs[6] = '{8'hC4, 8'h87, {S1, S3, S5}, {S1, S3, S5}, {SD, SD}, 1'b1};
        vecs[7] = '{8'hF4, 8'hA7, {S1, S6, S7}, {S1, S6, S7}, {SD, SD}, 1'b1};
        vecs[8] = '{8'h3C, 8'h28, {SB, S4, S0}, {S0, S4, S0}, {S4, S0}, 1'b0};

        // Held in reset
        @(negedge clk);
        chk("rst_seg", {25'd0, seg_m}, {25'd0, SB});
        chk("rst_an", {29'd0, an_m}, 32'd7);
        chk("rst_busy", {31'd0, busy_m}, 32'd0);
        chk("rst_bin", {24'd0, bin_m}, 32'd0);
        chk("rst_ovf", {31'd0, ovf_m}, 32'd0);

        // Idle scan after release: index advances every 4 clocks, only units lit
        rst_n = 1'b1;
        #1;
        chk("scan_c0_an", {29'd0, an_m}, {29'd0, an_tab[0]});
        chk("scan_c0_seg", {25'd0, seg_m}, {25'd0, S0});
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            chk($sformatf("scan_c%0d_an", c), {29'd0, an_m}, {29'd0, an_tab[(c / 4) % 3]});
            chk($sformatf("scan_c%0d_seg", c), {25'd0, seg_m},
                {25'd0, (((c / 4) % 3) == 0) ? S0 : SB});
            chk($sformatf("scan_c%0d_nolz", c), {25'd0, seg_n}, {25'd0, S0});
        end

        for (int i = 0; i < 9; i++) apply(i);

        // Exact latency: display registers change at edge k+N+2 (seen via d2 overflow)
        do_load(8'h00);
        wait_idle();
        do_load(8'h80);
        repeat (8) @(negedge clk);
        @(negedge clk);
        chk("lat_busy_k9", {31'd0, busy_m}, 32'd1);
        chk("lat_ovf_k9", {31'd0, ovf_d}, 32'd0);
        @(negedge clk);
        chk("lat_busy_k10", {31'd0, busy_m}, 32'd0);
        chk("lat_ovf_k10", {31'd0, ovf_d}, 32'd1);
        chk_disp("lat", vecs[0].sm, vecs[0].sn, vecs[0].sd);

        // Load while busy is ignored
        do_load(8'h0F);
        wait_idle();
        do_load(8'h80);
        gray = 8'h00;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        chk("busyld_bin", {24'd0, bin_m}, 32'hFF);
        wait_idle();
        chk("busyld_bin_after", {24'd0, bin_m}, 32'hFF);
        @(negedge clk);
        chk("busyld_no_requeue", {31'd0, busy_m}, 32'd0);
        chk_disp("busyld", vecs[0].sm, vecs[0].sn, vecs[0].sd);

        // Reset mid-conversion
        do_load(8'h80);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", {31'd0, busy_m}, 32'd0);
        chk("abort_bin", {24'd0, bin_m}, 32'd0);
        chk("abort_seg", {25'd0, seg_m}, {25'd0, SB});
        chk("abort_an", {29'd0, an_m}, 32'd7);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("abort_rel_busy", {31'd0, busy_m}, 32'd0);
        chk("abort_rel_ovf_d2", {31'd0, ovf_d}, 32'd0);
        chk_disp("abort", vecs[4].sm, vecs[4].sn, vecs[4].sd);
        apply(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
